// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the switch/button input conditioner.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } db_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 20000;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: synchronizer chain, debounce FSM with stability counter, edge pulses.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    db_state_e              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: if (sync) begin
                state_d = PEND_HI;
                cnt_d   = CntW'(1);
            end
            PEND_HI: begin
                if (!sync) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            STABLE_HI: if (!sync) begin
                state_d = PEND_LO;
                cnt_d   = CntW'(1);
            end
            PEND_LO: begin
                if (sync) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the raw switch/button pins and latches the lowest-index press as a
// valid/ack event for the game FSM.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    localparam int unsigned IdxW           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             evt_valid,
    output logic [IdxW-1:0]  evt_idx,
    input  logic             evt_ack,
    output logic             evt_overflow
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw_in     (raw_in[i]),
            .level_out  (level_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    logic            any_rise;
    logic [IdxW-1:0] cand;
    logic            valid_q, valid_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            ovf_q, ovf_d;

    // Scan downward so the lowest set index wins.
    always_comb begin
        cand = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rise_pulse[i]) cand = IdxW'(i);
        end
    end

    assign any_rise = |rise_pulse;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        if (any_rise) begin
            if (!valid_q || evt_ack) begin
                valid_d = 1'b1;
                idx_d   = cand;
                if (valid_q) ovf_d = 1'b0;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && evt_ack) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_valid    = valid_q;
    assign evt_idx      = idx_q;
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] raw_in;
    logic [7:0] level_out, rise_pulse, fall_pulse;
    logic       evt_valid, evt_ack, evt_overflow;
    logic [2:0] evt_idx;

    int checks   = 0;
    int failures = 0;

    input_conditioner #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_in       (raw_in),
        .level_out    (level_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .evt_valid    (evt_valid),
        .evt_idx      (evt_idx),
        .evt_ack      (evt_ack),
        .evt_overflow (evt_overflow)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with all pins held high.
        rst_n   = 1'b0;
        raw_in  = 8'hFF;
        evt_ack = 1'b0;
        #1;
        chk("rst_level", 32'(level_out), 32'h00);
        chk("rst_rise", 32'(rise_pulse), 32'h00);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        step(3);
        chk("rst_hold_level", 32'(level_out), 32'h00);
        chk("rst_hold_ovf", 32'(evt_overflow), 32'h0);
        rst_n = 1'b1;
        step(5);
        chk("rel_e5_level", 32'(level_out), 32'h00);
        chk("rel_e5_rise", 32'(rise_pulse), 32'h00);
        step();
        chk("rel_e6_level", 32'(level_out), 32'hFF);
        chk("rel_e6_rise", 32'(rise_pulse), 32'hFF);
        step();
        chk("rel_e7_rise", 32'(rise_pulse), 32'h00);
        chk("rel_evt_valid", 32'(evt_valid), 32'h1);
        chk("rel_evt_idx", 32'(evt_idx), 32'h0);
        chk("rel_evt_ovf", 32'(evt_overflow), 32'h0);

        // Drop all pins and acknowledge the reset-time event.
        raw_in  = 8'h00;
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        chk("ack_clear_valid", 32'(evt_valid), 32'h0);
        step(4);
        chk("fall_e5", 32'(fall_pulse), 32'h00);
        step();
        chk("fall_e6", 32'(fall_pulse), 32'hFF);
        chk("fall_e6_level", 32'(level_out), 32'h00);
        step();
        chk("fall_e7", 32'(fall_pulse), 32'h00);

        // Clean press and release of bit 5.
        raw_in = 8'h20;
        step(5);
        chk("b5_e5_rise", 32'(rise_pulse), 32'h00);
        step();
        chk("b5_e6_rise", 32'(rise_pulse), 32'h20);
        chk("b5_e6_level", 32'(level_out), 32'h20);
        step();
        chk("b5_e7_rise", 32'(rise_pulse), 32'h00);
        chk("b5_e7_level", 32'(level_out), 32'h20);
        chk("b5_evt_idx", 32'(evt_idx), 32'h5);
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        chk("b5_ack_valid", 32'(evt_valid), 32'h0);
        chk("b5_idx_hold", 32'(evt_idx), 32'h5);
        raw_in = 8'h00;
        step(5);
        chk("b5_rel_e5", 32'(fall_pulse), 32'h00);
        step();
        chk("b5_rel_e6", 32'(fall_pulse), 32'h20);
        chk("b5_rel_level", 32'(level_out), 32'h00);

        // Bouncing bit 2: excursions too short to be accepted.
        raw_in = 8'h04; step(3);
        raw_in = 8'h00; step(1);
        raw_in = 8'h04; step(3);
        raw_in = 8'h00;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("bounce_rise", 32'(rise_pulse), 32'h00);
            chk("bounce_level", 32'(level_out), 32'h00);
        end
        raw_in = 8'h04;
        step(5);
        chk("b2_e5_rise", 32'(rise_pulse), 32'h00);
        step();
        chk("b2_e6_rise", 32'(rise_pulse), 32'h04);
        step();
        chk("b2_e7_rise", 32'(rise_pulse), 32'h00);
        chk("b2_evt_idx", 32'(evt_idx), 32'h2);
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        chk("b2_ack_valid", 32'(evt_valid), 32'h0);

        // Simultaneous presses of bits 3 and 6.
        raw_in = 8'h4C;
        step(6);
        chk("sim_rise", 32'(rise_pulse), 32'h48);
        chk("sim_level", 32'(level_out), 32'h4C);
        step();
        chk("sim_valid", 32'(evt_valid), 32'h1);
        chk("sim_idx", 32'(evt_idx), 32'h3);
        chk("sim_ovf", 32'(evt_overflow), 32'h0);
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        raw_in = 8'h00;
        step(7);
        chk("sim_rel_level", 32'(level_out), 32'h00);
        chk("sim_rel_valid", 32'(evt_valid), 32'h0);

        // Handshake: pending bit 1, then bit 4 pressed without ack.
        raw_in = 8'h02;
        step(7);
        chk("hs_idx1", 32'(evt_idx), 32'h1);
        raw_in = 8'h12;
        step(6);
        chk("hs_rise4", 32'(rise_pulse), 32'h10);
        step();
        chk("hs_idx_keep", 32'(evt_idx), 32'h1);
        chk("hs_ovf", 32'(evt_overflow), 32'h1);
        chk("hs_valid", 32'(evt_valid), 32'h1);
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        chk("hs_ack_valid", 32'(evt_valid), 32'h0);
        chk("hs_ack_ovf", 32'(evt_overflow), 32'h0);

        // Bit 0 becomes pending, then bit 7's press coincides with an ack.
        raw_in = 8'h13;
        step(3);
        raw_in = 8'h93;
        step(4);
        chk("hs_idx0", 32'(evt_idx), 32'h0);
        chk("hs_valid0", 32'(evt_valid), 32'h1);
        step(2);
        chk("hs_rise7", 32'(rise_pulse), 32'h80);
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        chk("hs_ackpress_valid", 32'(evt_valid), 32'h1);
        chk("hs_ackpress_idx", 32'(evt_idx), 32'h7);

        // Mid-operation reset while bit 0 is in PEND_HI with cnt=2.
        raw_in = 8'h00;
        step(8);
        chk("mid_pre_level", 32'(level_out), 32'h00);
        raw_in = 8'h01;
        step(4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_valid), 32'h0);
        chk("mid_rst_idx", 32'(evt_idx), 32'h0);
        chk("mid_rst_ovf", 32'(evt_overflow), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("mid_e5_rise", 32'(rise_pulse), 32'h00);
        step();
        chk("mid_e6_rise", 32'(rise_pulse), 32'h01);
        chk("mid_e6_level", 32'(level_out), 32'h01);
        step();
        chk("mid_evt_valid", 32'(evt_valid), 32'h1);
        chk("mid_evt_idx", 32'(evt_idx), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Front-end for the board's switch/button inputs (ui_in[7:0]).
- Per bit: synchronizes, debounces and edge-detects the raw pins.
- Presents clean levels and one-cycle press/release pulses.
- Latches the lowest-index press into a valid/ack event register that the game FSM consumes.
- It is the input-side counterpart of the seven-segment output driver and sits between the pins and the game logic.

Parameters:
WIDTH, 8, number of input bits conditioned
SYNC_STAGES, 2, flip-flops in each synchronizer chain (>=2)
DEBOUNCE_CYCLES, 20000, consecutive synchronized-stable cycles required to accept a change (>=2)

Ports:
clk  input  1  system clock (one clock domain)
rst_n  input  1  asynchronous, active-low reset
raw_in  input  WIDTH  asynchronous raw pins (buttons/DIP switches)
level_out  output  WIDTH  debounced level per bit
rise_pulse  output  WIDTH  one-cycle pulse when a bit's debounced level goes 0->1
fall_pulse  output  WIDTH  one-cycle pulse when a bit's debounced level goes 1->0
evt_valid  output  1  a press event is pending
evt_idx  output  $clog2(WIDTH)  index of the pending press
evt_ack  input  1  consumer acknowledge; completes the event when evt_valid=1
evt_overflow  output  1  sticky: a press was dropped while an event was pending

Behaviour:
- Reset (rst_n low, asynchronous): all synchronizer flops, level_out, rise_pulse, fall_pulse, evt_valid, evt_idx, evt_overflow and counters go to 0. Every bit's FSM goes to STABLE_LO.
- Reset released while a pin is held high: the bit is accepted as a normal rise, with the full latency, and generates rise_pulse.
- Synchronizer: a SYNC_STAGES-deep flop chain per bit. sync[i] is the last stage.
- Per-bit FSM (all registered):
  - STABLE_LO: if sync=1 -> PEND_HI, cnt<=1.
  - PEND_HI: if sync=0 -> STABLE_LO, cnt<=0. Else if cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, level<=1, rise_pulse<=1 for exactly one cycle. Else cnt<=cnt+1.
  - STABLE_HI and PEND_LO: mirror images of the above, producing fall_pulse and level<=0.
- Latency: level_out and its pulse update on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting the first edge that samples the new raw value as edge 1. With defaults 2+4 this is edge 6.
- Glitch rejection: a synchronized excursion shorter than DEBOUNCE_CYCLES cycles produces no level change and no pulse. The counter restarts on every reversal.
- Pulse timing: rise_pulse and level_out rise in the same cycle. Pulses never last longer than one cycle.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter never wraps.
- Event register:
  - When any rise_pulse bit is set, cand = lowest set index.
  - If evt_valid=0, or evt_ack=1 in the same cycle: evt_valid<=1, evt_idx<=cand. A simultaneous ack plus new press loads the new event, so evt_valid stays 1.
  - If evt_valid=1 and evt_ack=0: the press is dropped, evt_overflow<=1, and evt_idx is unchanged.
  - evt_ack with no new press: evt_valid<=0 and evt_overflow<=0 on the next edge.
  - evt_ack while evt_valid=0 is ignored.
  - Higher-index simultaneous rises are not queued and do not set overflow.
- evt_idx holds its last value when evt_valid=0.

Decomposition:
- Shared package: the per-bit state typedef (enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO}) and the default DEBOUNCE_CYCLES constant.
- Sub-module debounce_bit: one bit's synchronizer, FSM, counter and pulse generation, parameterized by SYNC_STAGES and DEBOUNCE_CYCLES. The top instantiates WIDTH of them via generate.
- The lowest-index priority encoder and the event register live in the top.

Test Plan (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: rst_n low for 3 cycles with raw_in=8'hFF, then release -> all outputs 0 during reset. level_out=8'hFF and rise_pulse=8'hFF for one cycle on edge 6 after release. evt_valid=1, evt_idx=0.
- Clean press: raw_in[5] 0->1 held -> rise_pulse=8'h20 for exactly one cycle on edge 6, level_out[5]=1 from then on. Release -> fall_pulse=8'h20 on edge 6 after release.
- Bounce: raw_in[2] high 3 cycles, low 1, high 3, low -> no pulses and level_out[2] stays 0. Then held high 4+ cycles -> single rise_pulse.
- Simultaneous presses: raw_in bits 3 and 6 rise on the same edge -> rise_pulse=8'h48, evt_idx=3, evt_overflow=0.
- Handshake: evt pending (idx 1) with evt_ack held 0, then bit 4 pressed -> evt_idx stays 1 and evt_overflow=1. Ack pulse -> evt_valid=0 and evt_overflow=0 next cycle. A press of bit 7 coinciding with an ack -> evt_valid stays 1, evt_idx=7.
- Mid-operation reset: assert rst_n during PEND_HI (cnt=2) -> outputs clear immediately. After release with the pin still high, the rise arrives after the full 6-edge latency.
